// File: rtl/int_sqrt_unrolled_pkg.sv
//------------------------------------------------------------------------------
// fpu_int_pkg : shared types and helpers for the integer square-root engine.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fpu_int_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } sqrt_state_t;

    // Radicand bits consumed per root digit.
    localparam int SQRT_PAIR_W = 2;

    function automatic int sqrt_iter(input int width, input int unroll);
        return width / (2 * unroll);
    endfunction

    // LSB index of the most significant radicand bit pair.
    function automatic int sqrt_lead_pair_lo(input int width);
        return width - SQRT_PAIR_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/int_sqrt_unrolled_nr_step.sv
//------------------------------------------------------------------------------
// sqrt_nr_step : one combinational non-restoring square-root digit step.
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sqrt_nr_step #(
    parameter int QW = 12
) (
    input  logic [QW+1:0] i_r,
    input  logic [QW-1:0] i_q,
    input  logic [1:0]    i_pair,
    output logic [QW+1:0] o_r,
    output logic [QW-1:0] o_q
);

    logic [QW+1:0] w_shift;
    logic          w_neg;

    assign w_shift = {i_r[QW-1:0], i_pair};
    assign w_neg   = i_r[QW+1];

    // A negative partial remainder is repaired by adding instead of subtracting.
    assign o_r = w_neg ? (w_shift + {i_q, 2'b11}) : (w_shift - {i_q, 2'b01});
    assign o_q = {i_q[QW-2:0], ~o_r[QW+1]};

endmodule

`default_nettype wire

// File: rtl/int_sqrt_unrolled.sv
//------------------------------------------------------------------------------
// int_sqrt_unrolled : iterative non-restoring integer square root resolving
//                     UNROLL root bits per clock, valid/ready on both sides.
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module int_sqrt_unrolled
    import fpu_int_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int UNROLL = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     n_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH/2-1:0]   q_o,
    output logic [WIDTH/2:0]     r_o,
    output logic                 busy_o
);

    localparam int QW      = WIDTH / 2;
    localparam int ITER    = sqrt_iter(WIDTH, UNROLL);
    localparam int CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int LEAD_LO = sqrt_lead_pair_lo(WIDTH);
    localparam int SHIFT   = SQRT_PAIR_W * UNROLL;

    generate
        if (((WIDTH % 2) != 0) || (WIDTH < 4) || ((QW % UNROLL) != 0)) begin : g_param_check
            $error("int_sqrt_unrolled: WIDTH must be even and >= 4, UNROLL must divide WIDTH/2");
        end
    endgenerate

    sqrt_state_t      r_state;
    sqrt_state_t      w_state_nxt;

    logic [WIDTH-1:0] r_rad;
    logic [QW+1:0]    r_r;
    logic [QW-1:0]    r_q;
    logic [CNT_W-1:0] r_cnt;
    logic [QW-1:0]    r_q_out;
    logic [QW:0]      r_r_out;
    logic             r_out_valid;

    logic [QW+1:0]    w_r [UNROLL+1];
    logic [QW-1:0]    w_q [UNROLL+1];
    logic [QW+1:0]    w_r_fixed;

    assign w_r[0] = r_r;
    assign w_q[0] = r_q;

    generate
        for (genvar j = 0; j < UNROLL; j++) begin : g_step
            sqrt_nr_step #(
                .QW(QW)
            ) u_step (
                .i_r   (w_r[j]),
                .i_q   (w_q[j]),
                .i_pair(r_rad[LEAD_LO - SQRT_PAIR_W*j +: SQRT_PAIR_W]),
                .o_r   (w_r[j+1]),
                .o_q   (w_q[j+1])
            );
        end
    endgenerate

    // Final correction brings a negative remainder back into [0, 2q].
    assign w_r_fixed = r_r[QW+1] ? (r_r + {1'b0, r_q, 1'b1}) : r_r;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid_i)        w_state_nxt = RUN;
            RUN:     if (r_cnt == '0)       w_state_nxt = FIX;
            FIX:                            w_state_nxt = DONE;
            DONE:    if (out_ready_i)       w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rad       <= '0;
            r_r         <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_q_out     <= '0;
            r_r_out     <= '0;
            r_out_valid <= 1'b0;
        end else if (flush_i) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_rad <= n_i;
                        r_r   <= '0;
                        r_q   <= '0;
                        r_cnt <= CNT_W'(ITER - 1);
                    end
                end
                RUN: begin
                    r_rad <= r_rad << SHIFT;
                    r_r   <= w_r[UNROLL];
                    r_q   <= w_q[UNROLL];
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                FIX: begin
                    r_r         <= w_r_fixed;
                    r_q_out     <= r_q;
                    r_r_out     <= w_r_fixed[QW:0];
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = (r_state == IDLE);
    assign busy_o      = (r_state != IDLE);
    assign out_valid_o = r_out_valid;
    assign q_o         = r_q_out;
    assign r_o         = r_r_out;

endmodule

`default_nettype wire

// File: tb/tb_int_sqrt_unrolled.sv
//------------------------------------------------------------------------------
// tb_int_sqrt_unrolled : directed bench for UNROLL = 1, 3 and 12 builds.
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_int_sqrt_unrolled;

    localparam int W  = 24;
    localparam int QW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid  [3];
    logic          in_ready  [3];
    logic          flush     [3];
    logic          out_valid [3];
    logic          out_ready [3];
    logic          busy      [3];
    logic [W-1:0]  n         [3];
    logic [QW-1:0] q         [3];
    logic [QW:0]   r         [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    int_sqrt_unrolled #(.WIDTH(W), .UNROLL(1)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .n_i(n[0]), .flush_i(flush[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .q_o(q[0]), .r_o(r[0]), .busy_o(busy[0]));

    int_sqrt_unrolled #(.WIDTH(W), .UNROLL(3)) u_dut3 (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .n_i(n[1]), .flush_i(flush[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .q_o(q[1]), .r_o(r[1]), .busy_o(busy[1]));

    int_sqrt_unrolled #(.WIDTH(W), .UNROLL(12)) u_dut12 (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .n_i(n[2]), .flush_i(flush[2]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
        .q_o(q[2]), .r_o(r[2]), .busy_o(busy[2]));

    // Golden floor(sqrt) by binary search.
    function automatic int unsigned isqrt(input int unsigned v);
        int unsigned lo = 0;
        int unsigned hi = 4096;
        while (hi - lo > 1) begin
            int unsigned mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else                hi = mid;
        end
        return lo;
    endfunction

    // Runs one complete transaction on DUT d; lat counts edges from accept to out_valid.
    task automatic do_sqrt(input int d, input logic [W-1:0] val,
                           output logic [QW-1:0] qo, output logic [QW:0] ro, output int lat);
        @(negedge clk);
        in_valid[d] = 1'b1;
        n[d]        = val;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        in_valid[d] = 1'b0;
        while (!out_valid[d] && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        qo = q[d];
        ro = r[d];
        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (q[0] !== 12'd0)   begin n_err++; $display("FAIL reset_q got=%0d exp=0", q[0]); end
        n_vec++; if (r[0] !== 13'd0)   begin n_err++; $display("FAIL reset_r got=%0d exp=0", r[0]); end
        n_vec++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid[0]); end
        n_vec++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy[0]); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (in_ready[d] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready dut=%0d got=%b exp=1", d, in_ready[d]); end
        end
    endtask

    task automatic test_basic();
        logic [W-1:0]  tv_n [5] = '{24'd144, 24'd145, 24'd15, 24'd0, 24'd16777215};
        logic [QW-1:0] tv_q [5] = '{12'd12, 12'd12, 12'd3, 12'd0, 12'd4095};
        logic [QW:0]   tv_r [5] = '{13'd0, 13'd1, 13'd6, 13'd0, 13'd8190};
        logic [QW-1:0] qo;
        logic [QW:0]   ro;
        int            lat;
        for (int i = 0; i < 5; i++) begin
            do_sqrt(0, tv_n[i], qo, ro, lat);
            n_vec++; if (qo !== tv_q[i]) begin n_err++; $display("FAIL basic_q n=%0d got=%0d exp=%0d", tv_n[i], qo, tv_q[i]); end
            n_vec++; if (ro !== tv_r[i]) begin n_err++; $display("FAIL basic_r n=%0d got=%0d exp=%0d", tv_n[i], ro, tv_r[i]); end
            n_vec++; if (lat != 13)      begin n_err++; $display("FAIL basic_latency n=%0d got=%0d exp=13", tv_n[i], lat); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        in_valid[0] = 1'b1;
        n[0]        = 24'd200;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
        n_vec++; if (out_valid[0] !== 1'b1) begin n_err++; $display("FAIL bp_wait_valid got=%b exp=1", out_valid[0]); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (out_valid[0] !== 1'b1 || q[0] !== 12'd14 || r[0] !== 13'd4 || in_ready[0] !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cyc=%0d got v=%b q=%0d r=%0d rdy=%b exp v=1 q=14 r=4 rdy=0",
                         i, out_valid[0], q[0], r[0], in_ready[0]);
            end
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[0] = 1'b0;
        n_vec++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL bp_valid_clear got=%b exp=0", out_valid[0]); end
        n_vec++; if (in_ready[0] !== 1'b1)  begin n_err++; $display("FAIL bp_idle_ready got=%b exp=1", in_ready[0]); end
        n_vec++; if (q[0] !== 12'd14)       begin n_err++; $display("FAIL bp_q_kept got=%0d exp=14", q[0]); end
        in_valid[0] = 1'b1;
        n[0]        = 24'd1000;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        n_vec++; if (busy[0] !== 1'b1) begin n_err++; $display("FAIL b2b_accept got=%b exp=1", busy[0]); end
        lat = 0;
        while (!out_valid[0] && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
        n_vec++; if (lat != 13)        begin n_err++; $display("FAIL b2b_latency got=%0d exp=13", lat); end
        n_vec++; if (q[0] !== 12'd31)  begin n_err++; $display("FAIL b2b_q got=%0d exp=31", q[0]); end
        n_vec++; if (r[0] !== 13'd39)  begin n_err++; $display("FAIL b2b_r got=%0d exp=39", r[0]); end
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[0] = 1'b0;
    endtask

    task automatic test_flush();
        logic [QW-1:0] qo;
        logic [QW:0]   ro;
        int            lat;
        logic          seen;
        do_sqrt(0, 24'd50, qo, ro, lat);
        n_vec++; if (qo !== 12'd7 || ro !== 13'd1) begin n_err++; $display("FAIL flush_pre got q=%0d r=%0d exp q=7 r=1", qo, ro); end
        @(negedge clk);
        in_valid[0] = 1'b1;
        n[0]        = 24'd1000;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        flush[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush[0] = 1'b0;
        n_vec++; if (busy[0] !== 1'b0)      begin n_err++; $display("FAIL flush_busy got=%b exp=0", busy[0]); end
        n_vec++; if (in_ready[0] !== 1'b1)  begin n_err++; $display("FAIL flush_ready got=%b exp=1", in_ready[0]); end
        n_vec++; if (q[0] !== 12'd7 || r[0] !== 13'd1) begin n_err++; $display("FAIL flush_kept got q=%0d r=%0d exp q=7 r=1", q[0], r[0]); end
        seen = 1'b0;
        repeat (20) begin @(posedge clk); @(negedge clk); if (out_valid[0]) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_output got=%b exp=0", seen); end
        flush[0]    = 1'b1;
        in_valid[0] = 1'b1;
        n[0]        = 24'd144;
        @(posedge clk);
        @(negedge clk);
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        n_vec++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL flush_blocks_accept got=%b exp=0", busy[0]); end
        do_sqrt(0, 24'd100, qo, ro, lat);
        n_vec++; if (qo !== 12'd10 || ro !== 13'd0 || lat != 13) begin
            n_err++; $display("FAIL flush_after got q=%0d r=%0d lat=%0d exp q=10 r=0 lat=13", qo, ro, lat);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid[0] = 1'b1;
        n[0]        = 24'd1000;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        reset = 1'b0;
        #1;
        n_vec++; if (q[0] !== 12'd0 || r[0] !== 13'd0) begin n_err++; $display("FAIL rst_mid_qr got q=%0d r=%0d exp 0 0", q[0], r[0]); end
        n_vec++; if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_ctrl got v=%b busy=%b exp 0 0", out_valid[0], busy[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (20) begin @(posedge clk); @(negedge clk); end
        n_vec++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_after got v=%b rdy=%b exp 0 1", out_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_unroll();
        logic [W-1:0]  tv_n [5] = '{24'd144, 24'd15, 24'd0, 24'd16777215, 24'd12345678};
        logic [QW-1:0] tv_q [5] = '{12'd12, 12'd3, 12'd0, 12'd4095, 12'd3513};
        logic [QW:0]   tv_r [5] = '{13'd0, 13'd6, 13'd0, 13'd8190, 13'd4509};
        logic [QW-1:0] qo;
        logic [QW:0]   ro;
        int            lat;
        int            exp_lat;
        int unsigned   v;
        int unsigned   gq;
        for (int d = 1; d < 3; d++) begin
            exp_lat = (d == 1) ? 5 : 2;
            for (int i = 0; i < 5; i++) begin
                do_sqrt(d, tv_n[i], qo, ro, lat);
                n_vec++;
                if (qo !== tv_q[i] || ro !== tv_r[i] || lat != exp_lat) begin
                    n_err++;
                    $display("FAIL unroll_dir dut=%0d n=%0d got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=%0d",
                             d, tv_n[i], qo, ro, lat, tv_q[i], tv_r[i], exp_lat);
                end
            end
            for (int i = 0; i < 30; i++) begin
                v  = $urandom & 32'h00FF_FFFF;
                gq = isqrt(v);
                do_sqrt(d, v[W-1:0], qo, ro, lat);
                n_vec++;
                if (qo !== gq[QW-1:0] || {19'd0, ro} !== (v - gq*gq) || lat != exp_lat) begin
                    n_err++;
                    $display("FAIL unroll_rand dut=%0d n=%0d got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=%0d",
                             d, v, qo, ro, lat, gq, v - gq*gq, exp_lat);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            flush[d]     = 1'b0;
            out_ready[d] = 1'b0;
            n[d]         = '0;
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_unroll();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
